// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt controller: register word offsets,
// the read value returned for unmapped offsets, DBCFG field layout and reset values.
package gpio_irq_pkg;

    localparam logic [21:0] OFF_RAW   = 22'd0;
    localparam logic [21:0] OFF_IM    = 22'd1;
    localparam logic [21:0] OFF_TYPE  = 22'd2;
    localparam logic [21:0] OFF_POL   = 22'd3;
    localparam logic [21:0] OFF_BOTH  = 22'd4;
    localparam logic [21:0] OFF_PEND  = 22'd5;
    localparam logic [21:0] OFF_DBCFG = 22'd6;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    // DBCFG: prescale value in the low bits, debounce enable in the top bit
    localparam int DBCFG_PRESC_LSB = 0;
    localparam int DBCFG_EN_BIT    = 31;

    // Reset values of the configuration registers
    localparam logic [31:0] RST_IM    = 32'h0;
    localparam logic [31:0] RST_TYPE  = 32'h0;
    localparam logic [31:0] RST_POL   = 32'h0;
    localparam logic [31:0] RST_BOTH  = 32'h0;
    localparam logic [31:0] RST_DBCFG = 32'h0;

endpackage

// File: rtl/gpio_irq_filter.sv
// Pin input conditioning: 2-FF synchronizer, optional prescaled 3-sample
// debounce filter, and a one-cycle delayed copy of the filtered value used
// for edge detection.
module gpio_irq_filter
    import gpio_irq_pkg::*;
#(
    parameter int NPINS   = 16,
    parameter int PRESC_W = 16
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NPINS-1:0]   pin_in,
    input  logic               db_en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               cnt_clr,
    output logic [NPINS-1:0]   filt,
    output logic [NPINS-1:0]   filt_d
);

    logic [NPINS-1:0]   s1;
    logic [NPINS-1:0]   s2;
    logic [NPINS-1:0]   hist0;
    logic [NPINS-1:0]   hist1;
    logic [NPINS-1:0]   agree;
    logic [PRESC_W-1:0] cnt;
    logic               tick;

    // Sample tick: counter wraps after reaching the prescale value, so P=0 ticks every cycle
    assign tick  = db_en & (cnt == presc);
    // A pin may change only when the current sample and both older samples agree
    assign agree = ~(s2 ^ hist0) & ~(s2 ^ hist1);

    // Two-stage synchronizer for the asynchronous pin levels
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pin_in;
            s2 <= s1;
        end
    end

    // Debounce prescaler; held at zero while debounce is off and restarted on DBCFG writes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt <= '0;
        end else if (cnt_clr || !db_en) begin
            cnt <= '0;
        end else if (cnt == presc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sample history, shifted once per tick
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hist0 <= '0;
            hist1 <= '0;
        end else if (tick) begin
            hist1 <= hist0;
            hist0 <= s2;
        end
    end

    // Filtered value: follows s2 directly, or only on three agreeing ticked samples
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            filt <= '0;
        end else if (!db_en) begin
            filt <= s2;
        end else if (tick) begin
            filt <= (agree & s2) | (~agree & filt);
        end
    end

    // Delayed filtered value for edge detection
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            filt_d <= '0;
        end else begin
            filt_d <= filt;
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// AHB-lite slave that turns GPIO input pins into a maskable interrupt source.
// Holds the bus front end, configuration registers, pending logic and IRQ outputs.
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int NPINS   = 16,
    parameter int PRESC_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [23:2]      HADDR,
    input  logic             HREADY,
    input  logic             HWRITE,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic [1:0]       HRESP,
    input  logic [NPINS-1:0] GPIO_IN,
    input  logic [NPINS-1:0] GPIO_DIR,
    output logic [NPINS-1:0] IRQ_PIN,
    output logic             IRQ
);

    // Bus handshake: an address phase is accepted when HSEL and HREADY are both
    // high; it is a real transfer when HTRANS[1] is set (NONSEQ/SEQ). The data
    // phase follows in the next cycle and always completes in one cycle since
    // HREADYOUT is tied high. Writes commit at the end of that data phase, read
    // data is driven during it.
    logic             a_valid;
    logic             a_write;
    logic [21:0]      a_addr;
    logic [2:0]       a_size;

    logic [NPINS-1:0] im;
    logic [NPINS-1:0] typ;
    logic [NPINS-1:0] pol;
    logic [NPINS-1:0] both;
    logic [PRESC_W-1:0] presc;
    logic             db_en;
    logic [NPINS-1:0] pend_edge;

    logic [NPINS-1:0] filt;
    logic [NPINS-1:0] filt_d;
    logic [NPINS-1:0] wdata;
    logic [NPINS-1:0] edge_set;
    logic [NPINS-1:0] w1c_mask;
    logic [NPINS-1:0] type_chg;
    logic [NPINS-1:0] pend;
    logic [31:0]      dbcfg_rd;
    logic             wr_en;
    logic             unused_bits;

    assign HREADYOUT   = 1'b1;
    assign HRESP       = 2'b00;
    assign wr_en       = a_valid & a_write;
    assign wdata       = HWDATA[NPINS-1:0];
    assign unused_bits = ^{a_size, HTRANS[0], HWDATA};

    // Address phase capture; the address is held while the slave is not selected
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid <= 1'b0;
            a_write <= 1'b0;
            a_addr  <= '0;
            a_size  <= '0;
        end else begin
            a_valid <= HSEL & HREADY & HTRANS[1];
            if (HSEL && HREADY) begin
                a_write <= HWRITE;
                a_addr  <= HADDR;
                a_size  <= HSIZE;
            end
        end
    end

    // Configuration register writes at the data-phase edge
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            im    <= RST_IM[NPINS-1:0];
            typ   <= RST_TYPE[NPINS-1:0];
            pol   <= RST_POL[NPINS-1:0];
            both  <= RST_BOTH[NPINS-1:0];
            presc <= RST_DBCFG[DBCFG_PRESC_LSB +: PRESC_W];
            db_en <= RST_DBCFG[DBCFG_EN_BIT];
        end else if (wr_en) begin
            case (a_addr)
                OFF_IM:   im   <= wdata;
                OFF_TYPE: typ  <= wdata;
                OFF_POL:  pol  <= wdata;
                OFF_BOTH: both <= wdata;
                OFF_DBCFG: begin
                    presc <= HWDATA[DBCFG_PRESC_LSB +: PRESC_W];
                    db_en <= HWDATA[DBCFG_EN_BIT];
                end
                default: ;
            endcase
        end
    end

    gpio_irq_filter #(
        .NPINS   (NPINS),
        .PRESC_W (PRESC_W)
    ) u_filter (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .pin_in  (GPIO_IN),
        .db_en   (db_en),
        .presc   (presc),
        .cnt_clr (wr_en && (a_addr == OFF_DBCFG)),
        .filt    (filt),
        .filt_d  (filt_d)
    );

    // Edge qualification, W1C mask and TYPE-change clear for the sticky bits
    always_comb begin
        edge_set = typ & ~GPIO_DIR & (filt ^ filt_d) & (both | ~(filt ^ pol));
        w1c_mask = '0;
        type_chg = '0;
        if (wr_en && (a_addr == OFF_PEND)) begin
            w1c_mask = wdata;
        end
        if (wr_en && (a_addr == OFF_TYPE)) begin
            type_chg = typ ^ wdata;
        end
    end

    // Sticky edge pending bits: a new edge beats a W1C, output pins and TYPE changes clear
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_edge <= '0;
        end else begin
            pend_edge <= ((pend_edge & ~w1c_mask) | edge_set) & ~GPIO_DIR & ~type_chg;
        end
    end

    // Visible pending: sticky bits for edge pins, live level match for level pins
    always_comb begin
        pend    = ((typ & pend_edge) | (~typ & ~(filt ^ pol))) & ~GPIO_DIR;
        IRQ_PIN = pend & im;
        IRQ     = |IRQ_PIN;
    end

    // Read mux from the registered address
    always_comb begin
        dbcfg_rd = '0;
        dbcfg_rd[DBCFG_PRESC_LSB +: PRESC_W] = presc;
        dbcfg_rd[DBCFG_EN_BIT] = db_en;
        case (a_addr)
            OFF_RAW:   HRDATA = 32'(filt);
            OFF_IM:    HRDATA = 32'(im);
            OFF_TYPE:  HRDATA = 32'(typ);
            OFF_POL:   HRDATA = 32'(pol);
            OFF_BOTH:  HRDATA = 32'(both);
            OFF_PEND:  HRDATA = 32'(pend);
            OFF_DBCFG: HRDATA = dbcfg_rd;
            default:   HRDATA = UNMAPPED_RDATA;
        endcase
    end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: directed scenarios plus randomized traffic, with a
// cycle-level behavioural model feeding expected read data and IRQ vectors
// into queues that a separate monitor drains and compares.
module tb_gpio_irq_ctrl;
  import gpio_irq_pkg::*;

  localparam int NP = 16;
  localparam int PW = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic [23:2]   HADDR = '0;
  logic          HREADY = 1'b1;
  logic          HWRITE = 1'b0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'b010;
  logic [31:0]   HWDATA = '0;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic [1:0]    HRESP;
  logic [NP-1:0] GPIO_IN = '0;
  logic [NP-1:0] GPIO_DIR = '1;
  logic [NP-1:0] IRQ_PIN;
  logic          IRQ;

  int n_tests = 0;
  int n_fail = 0;
  bit model_on = 1'b1;

  gpio_irq_ctrl #(.NPINS(NP), .PRESC_W(PW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HREADY(HREADY), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .GPIO_IN(GPIO_IN), .GPIO_DIR(GPIO_DIR), .IRQ_PIN(IRQ_PIN), .IRQ(IRQ)
  );

  // ---------------- clock ----------------
  always #5 HCLK = ~HCLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin samples taken at each clock edge, newest first. The filtered value seen
  // after an edge is the pin level sampled two edges earlier (two synchronizer
  // stages then the filter stage), so with debounce off filt = sample[2] and its
  // delayed copy is sample[3].
  logic [NP-1:0] samp_q[$];
  logic [NP-1:0] m_im, m_typ, m_pol, m_both, m_pend_edge;
  logic [PW-1:0] m_presc;
  logic          m_en;
  logic          dph_v, dph_w;
  logic [21:0]   dph_a;

  logic [31:0]   exp_q[$];
  logic [21:0]   exp_a_q[$];
  logic [31:0]   irq_q[$];

  function automatic logic [NP-1:0] samp(input int i);
    return (i < samp_q.size()) ? samp_q[i] : '0;
  endfunction

  function automatic logic [NP-1:0] m_pend();
    logic [NP-1:0] f;
    f = samp(2);
    return ((m_typ & m_pend_edge) | (~m_typ & ~(f ^ m_pol))) & ~GPIO_DIR;
  endfunction

  function automatic logic [31:0] m_read(input logic [21:0] a);
    case (a)
      OFF_RAW:   return 32'(samp(2));
      OFF_IM:    return 32'(m_im);
      OFF_TYPE:  return 32'(m_typ);
      OFF_POL:   return 32'(m_pol);
      OFF_BOTH:  return 32'(m_both);
      OFF_PEND:  return 32'(m_pend());
      OFF_DBCFG: return {m_en, 15'b0, m_presc};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge HCLK) begin
    logic [NP-1:0] f, fd, set_v, w1c, tchg, wd;
    if (!HRESETn) begin
      m_im = '0; m_typ = '0; m_pol = '0; m_both = '0; m_pend_edge = '0;
      m_presc = '0; m_en = 1'b0;
      dph_v = 1'b0; dph_w = 1'b0; dph_a = '0;
      samp_q.delete();
      exp_q.delete(); exp_a_q.delete(); irq_q.delete();
    end else begin
      f = samp(2);
      fd = samp(3);
      set_v = m_typ & ~GPIO_DIR & (f ^ fd) & (m_both | ~(f ^ m_pol));
      w1c = '0;
      tchg = '0;
      wd = HWDATA[NP-1:0];
      if (dph_v && dph_w) begin
        case (dph_a)
          OFF_IM:   m_im = wd;
          OFF_TYPE: begin tchg = m_typ ^ wd; m_typ = wd; end
          OFF_POL:  m_pol = wd;
          OFF_BOTH: m_both = wd;
          OFF_PEND: w1c = wd;
          OFF_DBCFG: begin m_presc = HWDATA[PW-1:0]; m_en = HWDATA[31]; end
          default: ;
        endcase
      end
      m_pend_edge = ((m_pend_edge & ~w1c) | set_v) & ~GPIO_DIR & ~tchg;
      samp_q.push_front(GPIO_IN);
      if (samp_q.size() > 6) void'(samp_q.pop_back());
      dph_v = HSEL && HTRANS[1];
      if (HSEL) begin
        dph_w = HWRITE;
        dph_a = HADDR;
      end
    end
    #2;
    if (model_on && HRESETn) begin
      irq_q.push_back(32'(m_pend() & m_im));
      if (dph_v && !dph_w) begin
        exp_q.push_back(m_read(dph_a));
        exp_a_q.push_back(dph_a);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge HCLK) begin
    logic [31:0] e;
    logic [21:0] a;
    if (HRESETn) begin
      if (irq_q.size() > 0) begin
        e = irq_q.pop_front();
        chk("irq_pin", 32'(IRQ_PIN), e);
        chk("irq", 32'(IRQ), 32'(|e));
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = exp_a_q.pop_front();
        chk($sformatf("read_off%0d", a), HRDATA, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [21:0] a, input logic [31:0] d);
    tick();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = 3'b010;
    tick();
    bus_idle();
    HWDATA = d;
  endtask

  task automatic ahb_read(input logic [21:0] a);
    tick();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = 3'b010;
    tick();
    bus_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    int p;
    logic [21:0] ra;

    // Reset. All pins configured as outputs so level-mode PEND reads 0.
    repeat (3) tick();
    chk("rst_irq", 32'(IRQ), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("hreadyout", 32'(HREADYOUT), 32'h1);
    chk("hresp", 32'(HRESP), 32'h0);
    HRESETn = 1'b1;
    for (int a = 0; a < 8; a++) ahb_read(22'(a));
    repeat (2) tick();
    GPIO_DIR = '0;

    // Rising edge on pin 0: IRQ exactly four edges after the pin change
    ahb_write(OFF_IM, 32'h1);
    ahb_write(OFF_TYPE, 32'h1);
    ahb_write(OFF_POL, 32'h1);
    repeat (4) tick();
    GPIO_IN[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("edge_lat_e%0d", k), 32'(IRQ), 32'(k == 4));
    end
    ahb_write(OFF_PEND, 32'h1);
    tick();
    chk("edge_w1c", 32'(IRQ), 32'h0);

    // New edge coinciding with the W1C write: the set wins
    GPIO_IN[0] = 1'b0;
    repeat (6) tick();
    GPIO_IN[0] = 1'b1;
    tick();
    ahb_write(OFF_PEND, 32'h1);
    tick();
    chk("set_beats_w1c", 32'(IRQ), 32'h1);
    ahb_read(OFF_PEND);
    ahb_write(OFF_PEND, 32'h1);

    // Level mode, active-low on pin 3
    GPIO_IN = '0;
    ahb_write(OFF_IM, 32'h8);
    ahb_write(OFF_TYPE, 32'h0);
    ahb_write(OFF_POL, 32'h0);
    repeat (4) tick();
    chk("lvl_active", 32'(IRQ), 32'h1);
    GPIO_IN[3] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("lvl_lat_e%0d", k), 32'(IRQ), 32'(k < 3));
    end
    GPIO_IN[3] = 1'b0;
    repeat (4) tick();
    ahb_write(OFF_PEND, 32'h8);
    repeat (2) tick();
    chk("lvl_w1c_ignored", 32'(IRQ), 32'h1);
    ahb_read(OFF_PEND);
    tick();
    GPIO_DIR[3] = 1'b1;
    #1;
    chk("lvl_dir_mask", 32'(IRQ), 32'h0);
    tick();
    GPIO_DIR = '0;

    // Both-edge mode on pin 2
    ahb_write(OFF_IM, 32'h4);
    ahb_write(OFF_TYPE, 32'h4);
    ahb_write(OFF_BOTH, 32'h4);
    repeat (3) tick();
    GPIO_IN[2] = 1'b1;
    repeat (6) tick();
    chk("both_rise", 32'(IRQ), 32'h1);
    ahb_read(OFF_PEND);
    ahb_write(OFF_PEND, 32'h4);
    tick();
    chk("both_clear", 32'(IRQ), 32'h0);
    GPIO_IN[2] = 1'b0;
    repeat (6) tick();
    chk("both_fall", 32'(IRQ), 32'h1);
    ahb_read(OFF_PEND);
    ahb_write(OFF_PEND, 32'h4);

    // Randomized traffic, debounce kept off
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: begin
          tick();
          p = $urandom_range(0, NP - 1);
          GPIO_IN[p] = ~GPIO_IN[p];
        end
        3: ahb_write(22'($urandom_range(1, 4)), $urandom);
        4: ahb_write(OFF_PEND, $urandom);
        5: begin
          tick();
          GPIO_DIR = NP'($urandom & $urandom & $urandom);
        end
        6, 7: begin
          ra = 22'($urandom_range(0, 8));
          ahb_read(ra);
        end
        8: ahb_write(22'($urandom_range(0, 8)), $urandom & 32'h7FFF_FFFF);
        default: repeat ($urandom_range(1, 5)) tick();
      endcase
    end
    repeat (4) tick();

    // Debounce, prescale 3 (tick every 4 cycles), pin 5 rising-edge interrupt
    model_on = 1'b0;
    GPIO_IN = '0;
    GPIO_DIR = '0;
    repeat (2) tick();
    ahb_write(OFF_IM, 32'h20);
    ahb_write(OFF_TYPE, 32'h20);
    ahb_write(OFF_POL, 32'h20);
    ahb_write(OFF_BOTH, 32'h0);
    ahb_write(OFF_DBCFG, 32'h8000_0003);
    repeat (20) tick();
    ahb_write(OFF_PEND, 32'hFFFF);
    ahb_read(OFF_RAW);
    tick();
    GPIO_IN[5] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 5) GPIO_IN[5] = 1'b0;
      chk($sformatf("db_pulse_raw_c%0d", k), 32'(HRDATA[5]), 32'h0);
      chk($sformatf("db_pulse_irq_c%0d", k), 32'(IRQ), 32'h0);
    end
    GPIO_IN[5] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 10) chk($sformatf("db_hold_early_c%0d", k), 32'(HRDATA[5]), 32'h0);
    end
    chk("db_hold_raw", 32'(HRDATA[5]), 32'h1);
    chk("db_hold_irq", 32'(IRQ), 32'h1);

    // Reset asserted during a write data phase: the write must not land
    tick();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = OFF_IM;
    tick();
    bus_idle();
    HWDATA = 32'hFFFF;
    HRESETn = 1'b0;
    repeat (3) tick();
    chk("rst2_hrdata", HRDATA, 32'h0);
    chk("rst2_irq", 32'(IRQ), 32'h0);
    HRESETn = 1'b1;
    model_on = 1'b1;
    ahb_read(OFF_IM);
    ahb_read(OFF_DBCFG);
    ahb_read(OFF_TYPE);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
AHB-lite slave that turns the 16 GPIO input pins into a configurable, maskable interrupt source. It sits beside the GPIO block on the AHB_sys_0 bus and takes the same pin input vector plus the direction vector.
Per-pin pipeline: 2-FF synchronizer, optional prescaled debounce filter, level or edge detection, sticky pending bits.
Outputs a per-pin IRQ vector and one combined IRQ to the system interrupt controller.

Parameters:
NPINS, 16, number of GPIO pins handled (1..32)
PRESC_W, 16, width of the debounce sample prescaler

Ports:
HCLK  in  1  system clock
HRESETn  in  1  reset, asynchronous assert, active-low
HSEL  in  1  AHB slave select
HADDR  in  22 ([23:2])  word address
HREADY  in  1  AHB bus ready
HWRITE  in  1  write control
HTRANS  in  2  AHB transfer type
HSIZE  in  3  transfer size (registered, unused; word access only)
HWDATA  in  32  write data
HRDATA  out  32  read data
HREADYOUT  out  1  always 1
HRESP  out  2  always 2'b00 (OKAY)
GPIO_IN  in  NPINS  asynchronous pin input levels
GPIO_DIR  in  NPINS  pin direction; 1 = output, which excludes the pin from interrupts
IRQ_PIN  out  NPINS  per-pin masked interrupt
IRQ  out  1  OR of IRQ_PIN

Behaviour:
AHB protocol:
- Address phase is registered (HSEL&HREADY, HADDR, HWRITE, HTRANS[1]).
- Write takes effect at the data-phase clock edge.
- Read data is combinational from the registered address.
- Unmapped read address returns 32'hDEADBEEF. Unmapped writes are ignored.
- Zero wait states.

Register map (word offset, access, reset value; bits above NPINS read 0):
- 0x0 RAW, RO: filtered pin value.
- 0x1 IM, RW, reset 0: interrupt mask.
- 0x2 TYPE, RW, reset 0: 0 = level, 1 = edge.
- 0x3 POL, RW, reset 0: level mode 1 = active-high; edge mode 1 = rising.
- 0x4 BOTH, RW, reset 0: edge mode only; 1 = both edges, POL ignored.
- 0x5 PEND, read / W1C: pending bits.
- 0x6 DBCFG, RW, reset 0: [PRESC_W-1:0] prescale value P; [31] debounce enable.

Synchronizer and filter:
- Every pin passes through s1 then s2.
- Debounce disabled: filt <= s2 every cycle.
- Debounce enabled: a prescaler counts 0..P and generates a tick, then wraps to 0. P = 0 gives a tick every cycle.
- On each tick, shift s2 into a 2-bit per-pin history. filt updates only when s2 and both history bits are equal (3 consecutive agreeing samples).
- Writing DBCFG clears the prescaler counter to 0.
- filt_d <= filt every cycle.

Edge pin (TYPE=1):
- Pending set condition: filt != filt_d AND (BOTH, or filt == POL).
- Set occurs at the edge after filt changes.
- Sticky until a W1C write of 1 to that bit.
- Set and W1C in the same cycle: set wins, bit stays 1.

Level pin (TYPE=0):
- PEND bit = (filt == POL), combinational from filt. Not sticky; W1C has no effect.

Pin masking:
- GPIO_DIR=1 forces that PEND bit to 0 in both modes and clears any sticky edge bit.
- Writing TYPE clears the sticky pending state of any bit whose TYPE changes.

Outputs:
- IRQ_PIN = PEND & IM; IRQ = |IRQ_PIN. Both combinational from registers, no extra stage.

Latency, debounce disabled, edge mode:
- Pin change sampled at edge 0 → s1 at edge 1, s2 at edge 2, filt at edge 3.
- PEND and IRQ asserted after edge 4.

Reset:
- Every flop clears, including s1, s2, filt, filt_d, history and prescaler.
- IRQ = 0; HRDATA reflects offset 0 (RAW = 0).
- Assertion mid-transfer aborts it; no partial write survives.

Decomposition:
- Shared package gpio_irq_pkg holds register offsets (RAW..DBCFG), the unmapped read value 32'hDEADBEEF, DBCFG field positions and reset values.
- Sub-module gpio_irq_filter contains the synchronizer, prescaler, history and filt/filt_d for the NPINS vector.
- The top level holds the AHB front end, register file, pending logic and IRQ.

Test Plan:
- Reset, then read offsets 0x0–0x6 and 0x7 → all 0 except 0x7 = 32'hDEADBEEF; IRQ = 0.
- IM=0x0001, TYPE=0x0001, POL=0x0001, debounce off; GPIO_IN[0] 0→1 → PEND=0x0001 and IRQ=1 exactly 4 edges later; write PEND=0x0001 → IRQ=0 next cycle.
- Same setup with a second rising edge timed so set coincides with the W1C write → PEND[0] stays 1.
- Level mode on pin 3, POL=0, IM=0x0008: drive GPIO_IN[3]=0 → IRQ=1; drive 1 → IRQ=0 after 3 edges; W1C has no effect; GPIO_DIR[3]=1 → IRQ=0.
- DBCFG = 0x8000_0003, pin 5 pulses high for 5 cycles (shorter than 3 ticks × 4 cycles) → RAW[5] never changes, no pending; pin held high for 16 cycles → RAW[5]=1.
- BOTH=0x0004, TYPE=0x0004: pin 2 toggles 0→1, clear, 1→0 → PEND[2] set after each edge.
